bitwise_logic_iter: RTL

BITWISE_LOGIC_ITER -- requirements
Module: bitwise_logic_iter

---
 rtl/bitwise_logic_iter_pkg.sv | 29 ++
 rtl/bitwise_logic_iter_logic_slice.sv | 46 ++++
 rtl/bitwise_logic_iter.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/bitwise_logic_iter_pkg.sv
// ---------------------------------------------------------------------------
// bitwise_logic_iter_pkg
// Shared definitions for the iterative bitwise logic unit: operation codes,
// controller state encoding and a helper that sizes the slice counter.
// ---------------------------------------------------------------------------
package bitwise_logic_iter_pkg;

    // Operation codes as presented on the op port. All four codes are defined.
    typedef enum logic [1:0] {
        OP_AND = 2'b00,
        OP_OR  = 2'b01,
        OP_XOR = 2'b10,
        OP_NOR = 2'b11
    } op_e;

    // Controller states, binary encoded.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    // Slice counter width; a single-slice configuration still needs one bit
    // so the counter register is never zero-width.
    function automatic int cnt_width(input int nsl);
        return (nsl > 1) ? $clog2(nsl) : 1;
    endfunction

endpackage

// File: rtl/bitwise_logic_iter_logic_slice.sv
// ---------------------------------------------------------------------------
// logic_slice
// Combinational SLICE-wide bitwise unit built from gate primitives. All four
// gate results are formed per bit and the op code selects one of them.
//
// Ports
//   a   [SLICE-1:0]  operand A slice
//   b   [SLICE-1:0]  operand B slice
//   op  op_e         operation select (AND, OR, XOR, NOR)
//   y   [SLICE-1:0]  slice result
// ---------------------------------------------------------------------------
module logic_slice
    import bitwise_logic_iter_pkg::*;
#(
    parameter int SLICE = 8
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  op_e              op,
    output logic [SLICE-1:0] y
);

    logic [SLICE-1:0] y_and;
    logic [SLICE-1:0] y_or;
    logic [SLICE-1:0] y_xor;
    logic [SLICE-1:0] y_nor;

    for (genvar i = 0; i < SLICE; i++) begin : g_bit
        and u_and (y_and[i], a[i], b[i]);
        or  u_or  (y_or[i],  a[i], b[i]);
        xor u_xor (y_xor[i], a[i], b[i]);
        nor u_nor (y_nor[i], a[i], b[i]);
    end

    always_comb begin
        y = y_and;
        case (op)
            OP_AND:  y = y_and;
            OP_OR:   y = y_or;
            OP_XOR:  y = y_xor;
            OP_NOR:  y = y_nor;
            default: y = y_and;
        endcase
    end

endmodule

// File: rtl/bitwise_logic_iter.sv
// ---------------------------------------------------------------------------
// bitwise_logic_iter
// Iterative bitwise logic unit. Operands are latched on accept, then one
// SLICE-wide chunk of the result is produced per cycle by a single shared
// logic_slice instance. After WIDTH/SLICE cycles the full result is offered
// with a valid/ready handshake, together with zero and parity flags.
//
// Ports
//   clk        in   clock, all state on the rising edge
//   reset      in   asynchronous active-high reset
//   flush      in   synchronous abort back to IDLE (result register kept)
//   in_valid   in   operands/op presented
//   in_ready   out  high only in IDLE
//   a, b       in   [WIDTH-1:0] operands
//   op         in   [1:0] 00 AND, 01 OR, 10 XOR, 11 NOR
//   out_valid  out  high only in DONE
//   out_ready  in   consumer accepts result
//   result     out  [WIDTH-1:0] bitwise result
//   zero       out  result is all zeros
//   parity     out  XOR reduction of result
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | waiting for in_valid; in_ready high
// BUSY    | one slice written per cycle, counter selects the slice
// DONE    | full result offered; held until out_ready or flush
// ---------------------------------------------------------------------------
module bitwise_logic_iter
    import bitwise_logic_iter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             parity
);

    localparam int NSL = WIDTH / SLICE;
    localparam int CW  = cnt_width(NSL);
    localparam logic [CW-1:0] CNT_LAST = CW'(NSL - 1);

    state_e           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    op_e              op_q;

    logic [SLICE-1:0] a_sl;
    logic [SLICE-1:0] b_sl;
    logic [SLICE-1:0] y_sl;

    // Counter-selected slice of the latched operands feeds the one shared
    // slice unit; only SLICE bits of logic are ever evaluated per cycle.
    always_comb begin
        a_sl = a_q[SLICE-1:0];
        b_sl = b_q[SLICE-1:0];
        for (int k = 0; k < NSL; k++) begin
            if (cnt == CW'(k)) begin
                a_sl = a_q[k*SLICE +: SLICE];
                b_sl = b_q[k*SLICE +: SLICE];
            end
        end
    end

    logic_slice #(
        .SLICE (SLICE)
    ) u_slice (
        .a  (a_sl),
        .b  (b_sl),
        .op (op_q),
        .y  (y_sl)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= OP_AND;
            result    <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else if (flush) begin
            // Abort from any state; the result register keeps whatever
            // slices were already written.
            state     <= ST_IDLE;
            cnt       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_q      <= a;
                        b_q      <= b;
                        op_q     <= op_e'(op);
                        cnt      <= '0;
                        state    <= ST_BUSY;
                        in_ready <= 1'b0;
                    end
                end
                ST_BUSY: begin
                    for (int k = 0; k < NSL; k++) begin
                        if (cnt == CW'(k)) begin
                            result[k*SLICE +: SLICE] <= y_sl;
                        end
                    end
                    if (cnt == CNT_LAST) begin
                        cnt       <= '0;
                        state     <= ST_DONE;
                        out_valid <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    // in_ready stays low here, so a new accept can only
                    // happen from IDLE on a later edge.
                    if (out_ready) begin
                        state     <= ST_IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    cnt       <= '0;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

    // Flags derive from the registered result, so they are stable whenever
    // result is (in particular throughout DONE).
    assign zero   = ~|result;
    assign parity = ^result;

endmodule
